// File: rtl/aes_block_assembler.sv
// Packs NWORDS consecutive FIFO words (first word at the MSB end) into one block and offers it on valid/ready.
// Optional early flush with zero padding is enabled by defining AES_ASM_FLUSH_EN.
module aes_block_assembler #(
    parameter int WIDTH      = 8,
    parameter int BLOCK_BITS = 128,
    localparam int NWORDS    = BLOCK_BITS / WIDTH,
    localparam int CW        = $clog2(NWORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fifo_empty,
    input  logic [WIDTH-1:0]      fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  blk_valid,
    output logic [BLOCK_BITS-1:0] blk_data,
    input  logic                  blk_ready,
`ifdef AES_ASM_FLUSH_EN
    input  logic                  flush,
`endif
    output logic [CW-1:0]         fill_level
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] NW = CW'(NWORDS);

    state_t                  state_q, state_d;
    logic [CW-1:0]           req_q, req_d;
    logic [CW-1:0]           cap_q, cap_d;
    logic                    pend_q, pend_d;
    logic                    flushing_q, flushing_d;
    logic [BLOCK_BITS-1:0]   data_q, data_d;
    logic                    rd_en;
    logic                    flush_req;
    logic                    flush_go;

`ifdef AES_ASM_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // A flush only means something once the block has at least one word captured or in flight.
    assign flush_go = flush_req && (state_q == FILL) && ((cap_q != '0) || pend_q);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cap_d      = cap_q;
        pend_d     = 1'b0;
        flushing_d = flushing_q;
        data_d     = data_q;
        rd_en      = 1'b0;

        case (state_q)
            FILL: begin
                // Gated by rstn so no word is popped and silently lost while reset is held.
                rd_en = rstn && !fifo_empty && (req_q < NW) && !flushing_q && !flush_go;
                if (rd_en) begin
                    req_d  = req_q + 1'b1;
                    pend_d = 1'b1;
                end
                if (pend_q) begin
                    for (int i = 0; i < NWORDS; i++) begin
                        if (cap_q == CW'(i)) begin
                            data_d[BLOCK_BITS-1-i*WIDTH -: WIDTH] = fifo_dout;
                        end
                    end
                    cap_d = cap_q + 1'b1;
                end
                if (flushing_q || flush_go) begin
                    flushing_d = 1'b1;
                    // Remaining slots are already zero: data is cleared on every handshake.
                    if (!pend_q) begin
                        cap_d = NW;
                        req_d = NW;
                    end
                end
                if (cap_d == NW) begin
                    state_d    = HOLD;
                    flushing_d = 1'b0;
                end
            end
            HOLD: begin
                if (blk_ready) begin
                    state_d = FILL;
                    req_d   = '0;
                    cap_d   = '0;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= FILL;
            req_q      <= '0;
            cap_q      <= '0;
            pend_q     <= 1'b0;
            flushing_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cap_q      <= cap_d;
            pend_q     <= pend_d;
            flushing_q <= flushing_d;
            data_q     <= data_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign blk_valid  = (state_q == HOLD);
    assign blk_data   = data_q;
    assign fill_level = cap_q;

endmodule
